logic_unit_pipe: RTL
====================

// Module: logic_unit_pipe
// PURPOSE
//  Parametrised, registered successor to the single-bit 2-input gates: WIDTH-bit
//  bitwise logic unit with 8 selectable ops, zero/parity flags and valid/ready
//  handshake on both sides. One result register plus one skid register give full
//  throughput under backpressure. Feeds the CPU datapath as the ALU's logic slice.
// PARAMETERS
//  WIDTH     8   operand/result width in bits (>=1)
//  OP_W      3   opcode width (fixed at 3; kept as parameter for package consistency)
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      A/B/OP valid this cycle
//  in_ready   out  1      unit accepts A/B/OP this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  OP         in   3      opcode (see BEHAVIOUR)
//  out_valid  out  1      Y/Z/P hold a result
//  out_ready  in   1      consumer accepts result this cycle
//  Y          out  WIDTH  result
//  Z          out  1      1 when Y == 0
//  P          out  1      even parity of Y: ^Y
// BEHAVIOUR
//  - Opcodes: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 NOT A, 111 PASS A.
//    B is ignored for 110/111. All ops are bitwise; no carries, no width growth.
//  - Reset (async, while rst=1 and on release): out_valid=0, Y=0, Z=0, P=0,
//    skid empty. in_ready=0 while rst=1; in_ready=1 first cycle after release.
//  - Accept: input transfer when in_valid & in_ready at clk edge. Output transfer
//    when out_valid & out_ready at clk edge.
//  - Latency: 1 cycle. Accepted at edge N -> Y/Z/P/out_valid valid after edge N.
//  - Result computed at accept time; Z and P registered with Y (never from live Y).
//  - Output register load condition: (!out_valid | out_ready). Source priority:
//    skid entry if skid full, else incoming input. If no source, out_valid -> 0.
//  - Input accepted while output stalled (out_valid & !out_ready) goes to skid.
//  - in_ready = !skid_full, driven from register (no comb path out_ready->in_ready).
//  - Skid full + output drained: skid moves to output; same cycle new input may
//    enter skid only if in_ready was 1 (it was not) -> exactly one move per cycle.
//  - Simultaneous accept and drain with empty skid: new result replaces output,
//    out_valid stays 1 (back-to-back throughput 1/cycle).
//  - Y/Z/P hold stable while out_valid & !out_ready (AXI-style rule; bench checks).
//  - in_valid=0 with X on A/B/OP must not corrupt state. Ordering strictly FIFO.
//  - rst asserted mid-transfer: both entries discarded, no result emitted.
// STRUCTURE
//  - logic_unit_pkg: opcode localparams (OP_AND..OP_PASS), OP_W=3.
//  - Sub-module logic_op_comb (WIDTH): comb A,B,OP -> Y,Z,P; instantiated once on
//    the input side; output/skid registers store {Y,Z,P}.
//  - Top holds 2 x (WIDTH+2)-bit storage, skid_full flag, out_valid flag.
// TESTING
//  - Reset: rst=1 mid-run -> out_valid=0, Y=0, in_ready=0; release -> in_ready=1.
//  - Op sweep WIDTH=8, A=8'hF0, B=8'hCC, out_ready=1: Y = C0,FC,3C,3F,03,C3,0F,F0
//    for OP 0..7, each 1 cycle after accept; Z=0; P = ^Y.
//  - Flags: OP=AND A=8'hAA B=8'h55 -> Y=00, Z=1, P=0; OP=PASS A=8'h01 -> Z=0, P=1.
//  - Backpressure: out_ready=0, push 2 items (XOR 0F^FF, OR 00|01) -> in_ready=0
//    after 2nd; Y holds F0; raise out_ready -> F0 then 01 in order, in_ready -> 1.
//  - Streaming: in_valid=1 and out_ready=1 for 16 cycles random ops -> 16 results,
//    1/cycle, matching scoreboard, no bubbles.
//  - Random stall: random in_valid/out_ready 1000 cycles, WIDTH=1 and WIDTH=32 ->
//    scoreboard match, Y stable while stalled, no drops or duplicates.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared definitions for the registered bitwise logic unit.
// Opcode encodings are used by the datapath decoder and the logic slice alike.
package logic_unit_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND  = 3'b000;
    localparam logic [OP_W-1:0] OP_OR   = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR  = 3'b010;
    localparam logic [OP_W-1:0] OP_NAND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOR  = 3'b100;
    localparam logic [OP_W-1:0] OP_XNOR = 3'b101;
    localparam logic [OP_W-1:0] OP_NOTA = 3'b110;
    localparam logic [OP_W-1:0] OP_PASS = 3'b111;

endpackage

// File: rtl/logic_op_comb.sv
// Combinational core of the logic unit: bitwise op plus zero/parity flags.
module logic_op_comb
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [OP_W-1:0]  op_i,
    output logic [WIDTH-1:0] y_o,
    output logic             z_o,
    output logic             p_o
);

    always_comb begin
        y_o = '0;
        unique case (op_i)
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            OP_NAND: y_o = ~(a_i & b_i);
            OP_NOR:  y_o = ~(a_i | b_i);
            OP_XNOR: y_o = ~(a_i ^ b_i);
            OP_NOTA: y_o = ~a_i;
            default: y_o = a_i;
        endcase
    end

    assign z_o = (y_o == '0);
    assign p_o = ^y_o;

endmodule

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit logic unit with valid/ready on both sides.
// One output register plus one skid register sustain one result per cycle.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [OP_W-1:0]  OP,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             Z,
    output logic             P
);

    localparam int SW = WIDTH + 2;

    logic [WIDTH-1:0] res_y;
    logic             res_z;
    logic             res_p;
    logic [SW-1:0]    res_c;

    logic [SW-1:0] out_q;
    logic [SW-1:0] out_d;
    logic [SW-1:0] skid_q;
    logic [SW-1:0] skid_d;
    logic          out_valid_q;
    logic          out_valid_d;
    logic          skid_full_q;
    logic          skid_full_d;

    logic accept;
    logic load;

    logic_op_comb #(
        .WIDTH(WIDTH)
    ) u_op (
        .a_i (A),
        .b_i (B),
        .op_i(OP),
        .y_o (res_y),
        .z_o (res_z),
        .p_o (res_p)
    );

    assign res_c = {res_y, res_z, res_p};

    // Ready depends only on stored state, never on out_ready.
    assign in_ready = !skid_full_q && !rst;
    assign accept   = in_valid && in_ready;
    assign load     = !out_valid_q || out_ready;

    always_comb begin
        out_d       = out_q;
        skid_d      = skid_q;
        out_valid_d = out_valid_q;
        skid_full_d = skid_full_q;
        if (load) begin
            if (skid_full_q) begin
                out_d       = skid_q;
                out_valid_d = 1'b1;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_d       = res_c;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_d      = res_c;
            skid_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            skid_full_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            skid_full_q <= skid_full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign Y         = out_q[SW-1:2];
    assign Z         = out_q[1];
    assign P         = out_q[0];

endmodule
